cp0_ctrl: RTL and testbench

CP0_CTRL -- requirements
Module: cp0_ctrl

---
 rtl/cp0_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cp0_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_ctrl -- MIPS-style coprocessor 0: SR, Cause, EPC and PRId, plus the
// exception / interrupt request logic that redirects the pipeline.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   reset      : synchronous, active-high reset
//   A1         : mfc0 read register number
//   A2         : mtc0 write register number
//   DIn        : mtc0 write data
//   we         : mtc0 write enable (M stage)
//   VPC        : PC of the M-stage instruction (the victim)
//   BDIn       : victim sits in a branch delay slot
//   ExcCodeIn  : synchronous exception code from the M stage, 0 = none
//   HWInt      : hardware interrupt lines, level-sensitive
//   EXLClr     : eret in the M stage
//   DOut       : mfc0 read data, combinational from A1
//   EPCOut     : current EPC, to the next-PC logic
//   Req        : exception/interrupt request; next-PC forces the handler
//                address and the pipeline flushes
// -----------------------------------------------------------------------------
module cp0_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        we,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] DOut,
    output logic [31:0] EPCOut,
    output logic        Req
);

    localparam logic [4:0]  REG_SR    = 5'd12;
    localparam logic [4:0]  REG_CAUSE = 5'd13;
    localparam logic [4:0]  REG_EPC   = 5'd14;
    localparam logic [4:0]  REG_PRID  = 5'd15;
    localparam logic [31:0] PRID_VAL  = 32'h2021_0B0B;

    // Architectural state: only the implemented fields are stored.
    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    // Next-state values.
    logic [5:0]  sr_im_nxt;
    logic        sr_exl_nxt;
    logic        sr_ie_nxt;
    logic        cause_bd_nxt;
    logic [4:0]  cause_exc_nxt;
    logic [31:0] epc_nxt;

    logic        int_req;
    logic        exc_req;
    logic [31:0] epc_victim;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // -------------------------------------------------------------------------
    // Request logic. Everything is combinational so the flush happens in the
    // same cycle the victim is in M. EXL=1 masks both sources (no nesting).
    // -------------------------------------------------------------------------
    always_comb begin
        int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
        exc_req = (ExcCodeIn != 5'd0) & ~sr_exl;
        Req     = int_req | exc_req;
    end

    // Restart address of the victim: a delay-slot victim restarts at its
    // branch. The subtraction wraps modulo 2^32 and the word-align mask is
    // applied after it, so VPC=0 in a delay slot yields 0xFFFF_FFFC.
    always_comb begin
        epc_victim = (BDIn ? (VPC - 32'd4) : VPC) & 32'hFFFF_FFFC;
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Priority for every field: Req > EXLClr > mtc0.
    // A Req cancels the victim's own mtc0, so the write is dropped entirely.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path leaves a variable unassigned and no latch is inferred.
        sr_im_nxt     = sr_im;
        sr_exl_nxt    = sr_exl;
        sr_ie_nxt     = sr_ie;
        cause_bd_nxt  = cause_bd;
        cause_exc_nxt = cause_exc;
        epc_nxt       = epc;

        if (Req) begin
            sr_exl_nxt    = 1'b1;
            cause_bd_nxt  = BDIn;
            // Interrupts win over a simultaneous synchronous exception; the
            // exception re-occurs when the victim is re-executed.
            cause_exc_nxt = int_req ? 5'd0 : ExcCodeIn;
            epc_nxt       = epc_victim;
        end else begin
            if (we) begin
                case (A2)
                    REG_SR: begin
                        sr_im_nxt  = DIn[15:10];
                        sr_exl_nxt = DIn[1];
                        sr_ie_nxt  = DIn[0];
                    end
                    REG_EPC:  epc_nxt = DIn;
                    default: ;  // Cause, PRId and unimplemented numbers ignore mtc0
                endcase
            end
            // eret overrides an EXL value written by a concurrent mtc0,
            // while the IM/IE part of that write still lands.
            if (EXLClr) begin
                sr_exl_nxt = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register. Reset overrides Req, EXLClr and mtc0 in the same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers see pre-edge values, independent of statement order.
        if (reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            sr_im     <= sr_im_nxt;
            sr_exl    <= sr_exl_nxt;
            sr_ie     <= sr_ie_nxt;
            cause_bd  <= cause_bd_nxt;
            // IP mirrors the raw lines every cycle, regardless of masks/EXL.
            cause_ip  <= HWInt;
            cause_exc <= cause_exc_nxt;
            epc       <= epc_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Read side. DOut shows pre-edge state only; there is no bypass from a
    // concurrent mtc0 because the pipeline stalls around CP0 hazards.
    // -------------------------------------------------------------------------
    always_comb begin
        sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
        cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};

        case (A1)
            REG_SR:    DOut = sr_word;
            REG_CAUSE: DOut = cause_word;
            REG_EPC:   DOut = epc;
            REG_PRID:  DOut = PRID_VAL;
            default:   DOut = 32'd0;
        endcase

        EPCOut = epc;
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_ctrl -- directed bench for cp0_ctrl. Each step drives inputs right
// after a rising edge, lets combinational logic settle, then compares against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_cp0_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        we;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] DOut;
    logic [31:0] EPCOut;
    logic        Req;

    int n_vec  = 0;
    int n_miss = 0;

    cp0_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .A1        (A1),
        .A2        (A2),
        .DIn       (DIn),
        .we        (we),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .DOut      (DOut),
        .EPCOut    (EPCOut),
        .Req       (Req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and return shortly after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return all control inputs to a quiet state (HWInt left to the caller).
    task automatic idle();
        we        = 1'b0;
        A2        = 5'd0;
        DIn       = 32'd0;
        EXLClr    = 1'b0;
        ExcCodeIn = 5'd0;
        BDIn      = 1'b0;
        VPC       = 32'd0;
    endtask

    task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp);
        A1 = addr;
        #1;
        check(tag, DOut, exp);
    endtask

    task automatic chk_req(input string tag, input logic exp);
        #1;
        check(tag, {31'd0, Req}, {31'd0, exp});
    endtask

    initial begin
        reset  = 1'b1;
        A1     = 5'd0;
        HWInt  = 6'd0;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // ---- reset state ----
        chk_req("rst_req", 1'b0);
        check("rst_epcout", EPCOut, 32'h0);
        rd(5'd12, "rst_sr", 32'h0);
        rd(5'd13, "rst_cause", 32'h0);
        rd(5'd14, "rst_epc", 32'h0);
        rd(5'd15, "rst_prid", 32'h2021_0B0B);
        rd(5'd0,  "rst_a1_0", 32'h0);

        // ---- interrupt: SR=0xFC01, HWInt[2] ----
        we = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
        tick();
        idle();
        rd(5'd12, "sr_write", 32'h0000_FC01);
        chk_req("int_idle_req", 1'b0);
        HWInt = 6'b000100; VPC = 32'h0000_3000;
        chk_req("int_req", 1'b1);
        tick();
        idle();
        rd(5'd12, "int_sr_exl", 32'h0000_FC03);
        rd(5'd13, "int_cause", 32'h0000_1000);
        rd(5'd14, "int_epc", 32'h0000_3000);
        check("int_epcout", EPCOut, 32'h0000_3000);

        // ---- EXL masks, eret releases ----
        chk_req("exl_mask_req", 1'b0);
        ExcCodeIn = 5'd8;
        chk_req("exl_mask_exc", 1'b0);
        ExcCodeIn = 5'd0;
        EXLClr = 1'b1;
        tick();
        idle();
        VPC = 32'h0000_3004;
        chk_req("eret_req", 1'b1);
        rd(5'd12, "eret_sr", 32'h0000_FC01);
        tick();
        idle();
        HWInt = 6'd0;
        rd(5'd14, "reint_epc", 32'h0000_3004);

        // ---- synchronous exception in delay slot ----
        EXLClr = 1'b1;
        tick();
        idle();
        rd(5'd13, "clr_cause", 32'h0);
        ExcCodeIn = 5'd12; BDIn = 1'b1; VPC = 32'h0000_3010;
        chk_req("exc_req", 1'b1);
        tick();
        idle();
        rd(5'd14, "exc_epc", 32'h0000_300C);
        rd(5'd13, "exc_cause", 32'h8000_0030);
        rd(5'd12, "exc_sr", 32'h0000_FC03);

        // ---- interrupt and exception together: interrupt wins ----
        EXLClr = 1'b1;
        tick();
        idle();
        HWInt = 6'b000001; ExcCodeIn = 5'd4; VPC = 32'h0000_3020;
        chk_req("both_req", 1'b1);
        tick();
        idle();
        HWInt = 6'd0;
        rd(5'd13, "both_cause", 32'h0000_0400);
        rd(5'd14, "both_epc", 32'h0000_3020);

        // ---- mtc0 EPC in the victim's cycle is suppressed ----
        EXLClr = 1'b1;
        tick();
        idle();
        we = 1'b1; A2 = 5'd14; DIn = 32'h0000_3100;
        ExcCodeIn = 5'd8; VPC = 32'h0000_3040;
        chk_req("sup_req", 1'b1);
        tick();
        idle();
        rd(5'd14, "sup_epc", 32'h0000_3040);
        rd(5'd13, "sup_cause", 32'h0000_0020);
        rd(5'd15, "prid", 32'h2021_0B0B);

        // ---- plain mtc0 EPC (full width), mtc0 Cause ignored ----
        we = 1'b1; A2 = 5'd14; DIn = 32'h1234_5677;
        tick();
        idle();
        rd(5'd14, "mtc0_epc", 32'h1234_5677);
        we = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        tick();
        idle();
        rd(5'd13, "mtc0_cause_ign", 32'h0000_0020);

        // ---- eret together with mtc0 SR: IM/IE from DIn, EXL cleared ----
        we = 1'b1; A2 = 5'd12; DIn = 32'h0000_0402; EXLClr = 1'b1;
        tick();
        idle();
        rd(5'd12, "eret_mtc0_sr", 32'h0000_0400);

        // ---- VPC-4 wraparound ----
        we = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
        tick();
        idle();
        ExcCodeIn = 5'd10; BDIn = 1'b1; VPC = 32'h0000_0000;
        chk_req("wrap_req", 1'b1);
        tick();
        idle();
        rd(5'd14, "wrap_epc", 32'hFFFF_FFFC);
        rd(5'd13, "wrap_cause", 32'h8000_0028);

        // ---- misaligned VPC low bits cleared ----
        EXLClr = 1'b1;
        tick();
        idle();
        ExcCodeIn = 5'd4; VPC = 32'h0000_3013;
        tick();
        idle();
        rd(5'd14, "align_epc", 32'h0000_3010);
        rd(5'd13, "align_cause", 32'h0000_0010);
        rd(5'd16, "a1_16", 32'h0);
        rd(5'd31, "a1_31", 32'h0);

        // ---- reset during Req ----
        EXLClr = 1'b1;
        tick();
        idle();
        HWInt = 6'b000100; VPC = 32'h0000_3050;
        we = 1'b1; A2 = 5'd14; DIn = 32'h0000_5555;
        chk_req("prerst_req", 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        chk_req("postrst_req", 1'b0);
        rd(5'd12, "postrst_sr", 32'h0);
        rd(5'd13, "postrst_cause", 32'h0);
        rd(5'd14, "postrst_epc", 32'h0);
        check("postrst_epcout", EPCOut, 32'h0);
        rd(5'd15, "postrst_prid", 32'h2021_0B0B);
        HWInt = 6'd0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
